tx_credit_link: RTL and testbench



---
 rtl/tx_credit_link_pkg.sv | 17 +
 rtl/tx_credit_link_credit_counter.sv | 37 +++
 rtl/tx_credit_link.sv | 134 +++++++++++++
 tb/tb_tx_credit_link.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_credit_link_pkg.sv
// Shared types for the credit-based TX link that feeds the switch ingress port.
package tx_credit_link_pkg;

    typedef logic [31:0] chiplet_word_t;

    typedef enum logic [1:0] {
        LINK_DOWN = 2'd0,
        IDLE      = 2'd1,
        SEND      = 2'd2
    } tx_link_state_e;

    typedef struct packed {
        logic          last;
        chiplet_word_t data;
    } link_flit_t;

endpackage

// File: rtl/tx_credit_link_credit_counter.sv
// Saturating up/down credit counter: loads MAX on reset or clear, flags
// (sticky) a credit return that would overflow the switch buffer count.
module credit_counter #(
    parameter int MAX = 8,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         err
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= W'(MAX);
            err   <= 1'b0;
        end else if (clr) begin
            // Clear restores the full credit pool but keeps the error history.
            count <= W'(MAX);
        end else begin
            case ({inc, dec})
                2'b10: begin
                    if (count == W'(MAX)) err <= 1'b1;
                    else                  count <= count + W'(1);
                end
                2'b01: begin
                    if (count != '0) count <= count - W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/tx_credit_link.sv
// Credit-gated flit forwarder from the endpoint TX path to the switch ingress.
// Optional statistics counters are built when TX_CREDIT_LINK_STATS_EN is defined.
//
//   state     | meaning
//   LINK_DOWN | switch not ready; buffer flushed, credits at MAX, no traffic
//   IDLE      | link up, between packets
//   SEND      | link up, a packet has been started but its last flit not sent
module tx_credit_link
    import tx_credit_link_pkg::*;
#(
    parameter  int DEPTH       = 8,
    parameter  int MAX_CREDITS = 8,
    localparam int CRED_W      = $clog2(MAX_CREDITS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              link_up,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_flit,
    input  logic              in_last,
    output logic              out_valid,
    output logic [31:0]       out_flit,
    output logic              out_last,
    input  logic              credit_return,
    output logic [CRED_W-1:0] credits,
    output logic              credit_err,
    output logic              busy
`ifdef TX_CREDIT_LINK_STATS_EN
    ,
    output logic [15:0]       pkt_count,
    output logic [15:0]       stall_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    tx_link_state_e state;

    link_flit_t     mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic       link_active;
    logic       full;
    logic       empty;
    logic       push;
    logic       send;
    link_flit_t head_flit;

    assign link_active = (state != LINK_DOWN);
    assign full        = (count == CNT_W'(DEPTH));
    assign empty       = (count == '0);
    assign head_flit   = mem[head];

    assign in_ready = link_active && !full;
    assign push     = in_valid && in_ready;
    // A falling link_up suppresses any send in the same cycle.
    assign send     = link_active && link_up && !empty && (credits != '0);
    assign busy     = (state == SEND) || !empty;

    credit_counter #(
        .MAX (MAX_CREDITS),
        .W   (CRED_W)
    ) u_credit_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (!link_up),
        .inc   (credit_return),
        .dec   (send),
        .count (credits),
        .err   (credit_err)
    );

    always_ff @(posedge clk) begin
        if (push) mem[tail] <= '{last: in_last, data: in_flit};
    end

    always_ff @(posedge clk) begin
        if (rst || !link_up) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (send) head <= head + PTR_W'(1);
            case ({push, send})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LINK_DOWN;
            out_valid <= 1'b0;
            out_flit  <= '0;
            out_last  <= 1'b0;
        end else if (!link_up) begin
            state     <= LINK_DOWN;
            out_valid <= 1'b0;
        end else begin
            out_valid <= send;
            if (send) begin
                out_flit <= head_flit.data;
                out_last <= head_flit.last;
            end
            case (state)
                LINK_DOWN: state <= IDLE;
                IDLE:      if (send && !head_flit.last) state <= SEND;
                SEND:      if (send && head_flit.last)  state <= IDLE;
                default:   state <= LINK_DOWN;
            endcase
        end
    end

`ifdef TX_CREDIT_LINK_STATS_EN
    // Statistics survive link loss; only rst clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count   <= '0;
            stall_count <= '0;
        end else begin
            if (send && head_flit.last)    pkt_count   <= pkt_count + 16'd1;
            if ((state == SEND) && !send)  stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tx_credit_link.sv
// Self-checking bench for tx_credit_link: vector table, directed corner cases,
// and randomized traffic compared every cycle against a queue-based model.
module tb_tx_credit_link;

    localparam int DEPTH = 8;
    localparam int MAXC  = 8;
    localparam int CW    = $clog2(MAXC + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          link_up;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_flit;
    logic          in_last;
    logic          out_valid;
    logic [31:0]   out_flit;
    logic          out_last;
    logic          credit_return;
    logic [CW-1:0] credits;
    logic          credit_err;
    logic          busy;
`ifdef TX_CREDIT_LINK_STATS_EN
    logic [15:0]   pkt_count;
    logic [15:0]   stall_count;
`endif

    always #5 clk = ~clk;

    tx_credit_link #(
        .DEPTH       (DEPTH),
        .MAX_CREDITS (MAXC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .link_up       (link_up),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_flit       (in_flit),
        .in_last       (in_last),
        .out_valid     (out_valid),
        .out_flit      (out_flit),
        .out_last      (out_last),
        .credit_return (credit_return),
        .credits       (credits),
        .credit_err    (credit_err),
        .busy          (busy)
`ifdef TX_CREDIT_LINK_STATS_EN
        ,
        .pkt_count     (pkt_count),
        .stall_count   (stall_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a flit queue, a credit integer and a "mid-packet" flag.
    logic [32:0] mq[$];
    int          m_cr;
    bit          m_active;
    bit          m_inpkt;
    bit          m_err;
    bit          m_ov;
    logic [31:0] m_of;
    bit          m_ol;
`ifdef TX_CREDIT_LINK_STATS_EN
    logic [15:0] m_pkt;
    logic [15:0] m_stall;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_cr     = MAXC;
        m_active = 1'b0;
        m_inpkt  = 1'b0;
        m_err    = 1'b0;
        m_ov     = 1'b0;
        m_of     = '0;
        m_ol     = 1'b0;
`ifdef TX_CREDIT_LINK_STATS_EN
        m_pkt    = '0;
        m_stall  = '0;
`endif
    endfunction

    function automatic void model_step();
        bit          acc;
        bit          snd;
        logic [32:0] f;
        acc = in_valid && m_active && (mq.size() < DEPTH);
        snd = m_active && link_up && (mq.size() != 0) && (m_cr != 0);
`ifdef TX_CREDIT_LINK_STATS_EN
        if (m_inpkt && !snd) m_stall = m_stall + 16'd1;
`endif
        if (!link_up) begin
            mq.delete();
            m_cr     = MAXC;
            m_active = 1'b0;
            m_inpkt  = 1'b0;
            m_ov     = 1'b0;
        end else begin
            m_ov = snd;
            if (snd) begin
                f       = mq.pop_front();
                m_ol    = f[32];
                m_of    = f[31:0];
                m_inpkt = !f[32];
`ifdef TX_CREDIT_LINK_STATS_EN
                if (f[32]) m_pkt = m_pkt + 16'd1;
`endif
            end
            if (acc) mq.push_back({in_last, in_flit});
            if (snd && !credit_return) m_cr = m_cr - 1;
            else if (credit_return && !snd) begin
                if (m_cr == MAXC) m_err = 1'b1;
                else              m_cr  = m_cr + 1;
            end
            m_active = 1'b1;
        end
    endfunction

    task automatic model_check();
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("out_flit", out_flit, m_of);
        chk("out_last", 32'(out_last), 32'(m_ol));
        chk("credits", 32'(credits), 32'(m_cr));
        chk("credit_err", 32'(credit_err), 32'(m_err));
        chk("in_ready", 32'(in_ready), 32'(m_active && (mq.size() < DEPTH)));
        chk("busy", 32'(busy), 32'(m_inpkt || (mq.size() != 0)));
`ifdef TX_CREDIT_LINK_STATS_EN
        chk("pkt_count", 32'(pkt_count), 32'(m_pkt));
        chk("stall_count", 32'(stall_count), 32'(m_stall));
`endif
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        model_check();
    endtask

    task automatic set_in(input bit lu, input bit iv, input logic [31:0] fl,
                          input bit ls, input bit cr);
        link_up       = lu;
        in_valid      = iv;
        in_flit       = fl;
        in_last       = ls;
        credit_return = cr;
    endtask

    task automatic do_reset();
        set_in(0, 0, '0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit          lu;
        bit          iv;
        logic [31:0] fl;
        bit          ls;
        bit          cr;
        bit          e_ov;
        logic [31:0] e_of;
        bit          e_ol;
        int          e_cr;
        bit          e_ir;
        bit          e_busy;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [31:0] got_q[$];
        int          sent;

        vecs[0] = '{1, 0, 32'h0,        0, 0, 0, 32'h0,        0, 8, 1, 0};
        vecs[1] = '{1, 1, 32'hA0000001, 0, 0, 0, 32'h0,        0, 8, 1, 1};
        vecs[2] = '{1, 1, 32'hA0000002, 0, 0, 1, 32'hA0000001, 0, 7, 1, 1};
        vecs[3] = '{1, 1, 32'hA0000003, 1, 0, 1, 32'hA0000002, 0, 6, 1, 1};
        vecs[4] = '{1, 0, 32'h0,        0, 0, 1, 32'hA0000003, 1, 5, 1, 0};
        vecs[5] = '{1, 0, 32'h0,        0, 0, 0, 32'hA0000003, 1, 5, 1, 0};
        vecs[6] = '{1, 0, 32'h0,        0, 1, 0, 32'hA0000003, 1, 6, 1, 0};

        // Reset values
        do_reset();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_flit", out_flit, 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_credits", 32'(credits), MAXC);
        chk("rst_credit_err", 32'(credit_err), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_busy", 32'(busy), 0);

        // Three-flit packet, table driven
        for (int i = 0; i < 7; i++) begin
            set_in(vecs[i].lu, vecs[i].iv, vecs[i].fl, vecs[i].ls, vecs[i].cr);
            tick();
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            chk($sformatf("vec%0d_out_flit", i), out_flit, vecs[i].e_of);
            chk($sformatf("vec%0d_out_last", i), 32'(out_last), 32'(vecs[i].e_ol));
            chk($sformatf("vec%0d_credits", i), 32'(credits), 32'(vecs[i].e_cr));
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
        end

        // Ten flits, no credit returns: exactly MAXC go out
        do_reset();
        set_in(1, 0, '0, 0, 0);
        tick();
        sent = 0;
        for (int i = 0; i < 10; i++) begin
            set_in(1, 1, 32'hB0000000 + 32'(i), 0, 0);
            tick();
            if (out_valid) sent++;
        end
        set_in(1, 0, '0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (out_valid) sent++;
        end
        chk("starve_sent", 32'(sent), MAXC);
        chk("starve_credits", 32'(credits), 0);
        chk("starve_out_valid", 32'(out_valid), 0);
        set_in(1, 0, '0, 0, 1);
        tick();
        chk("ret1_out_valid", 32'(out_valid), 0);
        chk("ret1_credits", 32'(credits), 1);
        set_in(1, 0, '0, 0, 0);
        tick();
        chk("ninth_out_valid", 32'(out_valid), 1);
        chk("ninth_out_flit", out_flit, 32'hB0000008);
        chk("ninth_credits", 32'(credits), 0);

        // Simultaneous send and credit return, then overflow error
        do_reset();
        set_in(1, 0, '0, 0, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            set_in(1, 1, 32'hC0000000 + 32'(i), 1, 0);
            tick();
        end
        set_in(1, 0, '0, 0, 0);
        tick();
        tick();
        chk("pre_both_credits", 32'(credits), 4);
        set_in(1, 1, 32'hC00000FF, 1, 0);
        tick();
        set_in(1, 0, '0, 0, 1);
        tick();
        chk("both_out_valid", 32'(out_valid), 1);
        chk("both_credits", 32'(credits), 4);
        for (int i = 0; i < 4; i++) tick();
        chk("refill_credits", 32'(credits), MAXC);
        chk("refill_err", 32'(credit_err), 0);
        tick();
        chk("ovf_credits", 32'(credits), MAXC);
        chk("ovf_err", 32'(credit_err), 1);
        set_in(1, 0, '0, 0, 0);
        for (int i = 0; i < 3; i++) tick();
        chk("err_sticky", 32'(credit_err), 1);

        // Fill buffer while starved of credits, verify back-pressure and order
        do_reset();
        set_in(1, 0, '0, 0, 0);
        tick();
        for (int i = 0; i < MAXC; i++) begin
            set_in(1, 1, 32'hD0000000 + 32'(i), 1, 0);
            tick();
        end
        set_in(1, 0, '0, 0, 0);
        tick();
        tick();
        chk("drain_credits", 32'(credits), 0);
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1, 1, 32'hE0000000 + 32'(i), 1, 0);
            tick();
        end
        chk("full_in_ready", 32'(in_ready), 0);
        set_in(1, 1, 32'hE0000099, 1, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("full_hold_in_ready", 32'(in_ready), 0);
        end
        set_in(1, 0, '0, 0, 1);
        got_q.delete();
        for (int k = 0; k < 30 && got_q.size() < DEPTH; k++) begin
            tick();
            if (out_valid) got_q.push_back(out_flit);
        end
        chk("full_drain_count", 32'(got_q.size()), DEPTH);
        for (int i = 0; i < DEPTH && i < got_q.size(); i++)
            chk($sformatf("full_order%0d", i), got_q[i], 32'hE0000000 + 32'(i));

        // Link loss mid-packet, then a fresh packet
        do_reset();
        set_in(1, 0, '0, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 1, 32'hF0000000 + 32'(i), 0, 0);
            tick();
        end
        chk("pre_drop_out_flit", out_flit, 32'hF0000001);
        set_in(0, 0, '0, 0, 0);
        tick();
        chk("drop_out_valid", 32'(out_valid), 0);
        chk("drop_in_ready", 32'(in_ready), 0);
        chk("drop_busy", 32'(busy), 0);
        chk("drop_credits", 32'(credits), MAXC);
        set_in(1, 0, '0, 0, 0);
        tick();
        set_in(1, 1, 32'hF1000000, 0, 0);
        tick();
        set_in(1, 1, 32'hF1000001, 1, 0);
        tick();
        set_in(1, 0, '0, 0, 0);
        got_q.delete();
        for (int k = 0; k < 10 && got_q.size() < 3; k++) begin
            if (out_valid) got_q.push_back(out_flit);
            tick();
        end
        chk("relink_count", 32'(got_q.size()), 2);
        if (got_q.size() >= 2) begin
            chk("relink_f0", got_q[0], 32'hF1000000);
            chk("relink_f1", got_q[1], 32'hF1000001);
        end

        // Two packets with five stalled cycles mid-packet
        do_reset();
        set_in(1, 0, '0, 0, 0);
        tick();
        set_in(1, 1, 32'h11110000, 0, 0);
        tick();
        set_in(1, 0, '0, 0, 0);
        tick();
        for (int i = 0; i < 4; i++) tick();
        set_in(1, 1, 32'h11110001, 1, 0);
        tick();
        set_in(1, 1, 32'h22220000, 1, 0);
        tick();
        set_in(1, 0, '0, 0, 0);
        tick();
        tick();
        chk("stats_seq_busy", 32'(busy), 0);
`ifdef TX_CREDIT_LINK_STATS_EN
        chk("stats_pkt", 32'(pkt_count), 2);
        chk("stats_stall", 32'(stall_count), 5);
`endif

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            set_in($urandom_range(0, 79) != 0,
                   $urandom_range(0, 2) != 0,
                   $urandom(),
                   $urandom_range(0, 3) == 0,
                   $urandom_range(0, 9) < 4);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
